// File: rtl/pc_gen_if.sv
// Control-side bundle for the fetch-stage program-counter generator.
// The master modport is the control unit; the slave modport is pc_gen itself.
interface pc_gen_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic                i_stall;
    logic [2:0]          i_sel;
    logic [PC_WIDTH-1:0] i_imm_val;
    logic [PC_WIDTH-1:0] i_reg_val;
    logic                i_push;
    logic [PC_WIDTH-1:0] o_pc_val;
    logic [PC_WIDTH-1:0] o_pc_val_inc;
    logic                o_redirect;
    logic                o_ras_empty;
    logic                o_ras_full;
    logic                o_ras_miss;

    modport master (
        output i_stall, i_sel, i_imm_val, i_reg_val, i_push,
        input  o_pc_val, o_pc_val_inc, o_redirect, o_ras_empty, o_ras_full, o_ras_miss
    );

    modport slave (
        input  i_stall, i_sel, i_imm_val, i_reg_val, i_push,
        output o_pc_val, o_pc_val_inc, o_redirect, o_ras_empty, o_ras_full, o_ras_miss
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage PC generator with stall, return-address stack and redirect pulse.
// Optional macro PC_ALIGN_CHECK_EN rejects word-misaligned targets and adds o_misalign.
module pc_gen #(
    parameter int unsigned          PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_VEC = '0,
    parameter int unsigned          INCR      = 4,
    parameter int unsigned          RAS_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    pc_gen_if.slave    bus
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic       o_misalign
`endif
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PC_WIDTH-1:0] LP_INCR  = PC_WIDTH'(INCR);
    localparam logic [CNT_W-1:0]    LP_DEPTH = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        OP_RST  = 3'd0,
        OP_INCR = 3'd1,
        OP_IMM  = 3'd2,
        OP_ALU  = 3'd3,
        OP_RET  = 3'd4
    } op_t;

    logic [PC_WIDTH-1:0] r_pc;
    logic [PTR_W-1:0]    r_top;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_redirect;
    logic                r_ras_miss;
    logic [PC_WIDTH-1:0] r_stack [RAS_DEPTH];

    op_t                 w_op;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_sum;
    logic [PC_WIDTH-1:0] w_alu;
    logic [PC_WIDTH-1:0] w_target;
    logic                w_empty;
    logic                w_full;
    logic                w_reject;
    logic                w_apply;
    logic [PTR_W-1:0]    w_top_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_wr_en;
    logic [PTR_W-1:0]    w_wr_ptr;

    assign w_pc_inc = r_pc + LP_INCR;
    assign w_sum    = bus.i_reg_val + bus.i_imm_val;
    assign w_alu    = {w_sum[PC_WIDTH-1:1], 1'b0};
    assign w_empty  = (r_cnt == '0);
    assign w_full   = (r_cnt == LP_DEPTH);

    // Unused encodings 5-7 fall back to sequential fetch.
    always_comb begin
        w_op = OP_INCR;
        if (bus.i_sel <= 3'd4) begin
            w_op = op_t'(bus.i_sel);
        end
    end

    always_comb begin
        w_target = w_pc_inc;
        case (w_op)
            OP_RST:  w_target = RESET_VEC;
            OP_INCR: w_target = w_pc_inc;
            OP_IMM:  w_target = r_pc + bus.i_imm_val;
            OP_ALU:  w_target = w_alu;
            OP_RET:  w_target = w_empty ? w_alu : r_stack[r_top];
            default: w_target = w_pc_inc;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    assign w_reject = (w_op != OP_RST) && (w_target[1:0] != 2'b00);
`else
    assign w_reject = 1'b0;
`endif

    assign w_apply = !bus.i_stall && !w_reject;

    // Stack bookkeeping: a combined pop+push rewrites the top entry in place.
    always_comb begin
        w_top_next = r_top;
        w_cnt_next = r_cnt;
        w_wr_en    = 1'b0;
        w_wr_ptr   = r_top;
        if (w_apply) begin
            if (w_op == OP_RST) begin
                w_top_next = '0;
                w_cnt_next = '0;
            end else if (w_op == OP_RET && bus.i_push) begin
                w_wr_en    = 1'b1;
                w_wr_ptr   = r_top;
                w_cnt_next = w_empty ? CNT_W'(1) : r_cnt;
            end else if (bus.i_push) begin
                w_wr_en    = 1'b1;
                w_wr_ptr   = r_top + 1'b1;
                w_top_next = r_top + 1'b1;
                w_cnt_next = w_full ? r_cnt : r_cnt + 1'b1;
            end else if (w_op == OP_RET && !w_empty) begin
                w_top_next = r_top - 1'b1;
                w_cnt_next = r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc       <= RESET_VEC;
            r_top      <= '0;
            r_cnt      <= '0;
            r_redirect <= 1'b0;
            r_ras_miss <= 1'b0;
        end else begin
            if (w_apply) begin
                r_pc <= w_target;
            end
            r_top      <= w_top_next;
            r_cnt      <= w_cnt_next;
            r_redirect <= w_apply && (w_op != OP_INCR);
            r_ras_miss <= w_apply && (w_op == OP_RET) && w_empty;
        end
    end

    // Stack contents need no reset; the count guards every read.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_stack[w_wr_ptr] <= w_pc_inc;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic r_misalign;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_misalign <= 1'b0;
        end else if (!bus.i_stall) begin
            if (w_op == OP_RST) begin
                r_misalign <= 1'b0;
            end else if (w_reject) begin
                r_misalign <= 1'b1;
            end
        end
    end

    assign o_misalign = r_misalign;
`endif

    assign bus.o_pc_val     = r_pc;
    assign bus.o_pc_val_inc = w_pc_inc;
    assign bus.o_redirect   = r_redirect;
    assign bus.o_ras_empty  = w_empty;
    assign bus.o_ras_full   = w_full;
    assign bus.o_ras_miss   = r_ras_miss;

endmodule
